// File: rtl/nn_pkg.sv
// Shared definitions for the MNIST image path: image geometry, the loader
// state encoding and the digit type returned by the classifier.
package nn_pkg;

    localparam int IMG_W      = 28;
    localparam int IMG_PIXELS = IMG_W * IMG_W;
    localparam int IMG_WORDS  = IMG_PIXELS / 2;

    typedef enum logic [1:0] {
        FILL,
        START,
        RESULT,
        DRAIN
    } ldr_state_t;

    typedef logic [3:0] digit_t;

endpackage

// File: rtl/img_word_ram.sv
// Image word buffer: NUM_WORDS x 16, one synchronous write port and one
// asynchronous read port. Reads at or beyond NUM_WORDS return zero.
//   clk      - write clock
//   we       - write enable
//   wr_addr  - write word index
//   wr_data  - write word
//   rd_addr  - read word index (full 16-bit classifier address)
//   rd_data  - combinational read data
module img_word_ram #(
    parameter int  NUM_WORDS = 392,
    localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [15:0]   rd_addr,
    output logic [15:0]   rd_data
);

    // No reset: contents persist across RESET, and this maps to distributed RAM.
    logic [15:0] mem_q [NUM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // The classifier keeps counting past the image; those reads must be zero.
    always_comb begin
        rd_data = 16'h0000;
        if (rd_addr < 16'(NUM_WORDS)) begin
            rd_data = mem_q[rd_addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/img_loader.sv
// Frame-capture front end for the MNIST classifier. Packs a raster byte
// stream two pixels per word into img_word_ram, runs the NN_START/NN_DONE
// handshake and returns the digit with a one-cycle strobe.
//   CLK, RESET            - clock, synchronous active-high reset
//   pix_valid/data/sof    - pixel byte stream in; pix_sof marks pixel 0
//   pix_ready             - byte accepted when pix_valid && pix_ready
//   address, Data         - classifier read port into the image buffer
//   NN_START, NN_DONE     - classifier handshake
//   prediction            - classifier result, bits [3:0] used
//   result_valid, result  - digit strobe and latched digit
//   busy                  - frame is with the classifier
//
// state  | meaning
// FILL   | accepting pixels into the buffer
// START  | NN_START high, waiting for NN_DONE
// RESULT | result just latched, result_valid high for this cycle
// DRAIN  | waiting for NN_DONE to drop before the next frame
module img_loader
    import nn_pkg::*;
#(
    parameter  int NUM_PIXELS = IMG_PIXELS,
    localparam int NUM_WORDS  = NUM_PIXELS / 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    input  logic        pix_sof,
    output logic        pix_ready,
    input  logic [15:0] address,
    output logic [15:0] Data,
    output logic        NN_START,
    input  logic        NN_DONE,
    input  logic [31:0] prediction,
    output logic        result_valid,
    output logic [3:0]  result,
    output logic        busy
);

    localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIXELS - 1);

    ldr_state_t    state_q, state_d;
    logic [PW-1:0] pidx_q, pidx_d;
    logic [7:0]    lo_byte_q, lo_byte_d;
    digit_t        result_q, result_d;

    logic [PW-1:0] eff_idx;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    logic          unused_pred;
    assign unused_pred = ^prediction[31:4];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= FILL;
            pidx_q    <= '0;
            lo_byte_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            pidx_q    <= pidx_d;
            lo_byte_q <= lo_byte_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pidx_d    = pidx_q;
        lo_byte_d = lo_byte_q;
        result_d  = result_q;
        wr_en     = 1'b0;
        // pix_sof restarts the frame on this very byte.
        eff_idx   = pix_sof ? '0 : pidx_q;
        wr_addr   = AW'(eff_idx >> 1);
        wr_data   = {pix_data, lo_byte_q};

        unique case (state_q)
            FILL: begin
                if (pix_valid) begin
                    if (!eff_idx[0]) begin
                        lo_byte_d = pix_data;
                        pidx_d    = eff_idx + PW'(1);
                    end else begin
                        wr_en = 1'b1;
                        if (eff_idx == LAST_PIX) begin
                            pidx_d  = '0;
                            state_d = START;
                        end else begin
                            pidx_d = eff_idx + PW'(1);
                        end
                    end
                end
            end
            START: begin
                if (NN_DONE) begin
                    result_d = prediction[3:0];
                    state_d  = RESULT;
                end
            end
            RESULT: state_d = DRAIN;
            DRAIN: begin
                if (!NN_DONE) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign pix_ready    = (state_q == FILL);
    assign NN_START     = (state_q == START);
    assign result_valid = (state_q == RESULT);
    assign busy         = (state_q != FILL);
    assign result       = result_q;

    img_word_ram #(
        .NUM_WORDS (NUM_WORDS)
    ) u_ram (
        .clk     (CLK),
        .we      (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (address),
        .rd_data (Data)
    );

endmodule
